// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch initiator. Holds the PC, drives the instruction memory read
// address, captures the same-cycle (combinational) read data and hands
// {pc, instruction} pairs to decode through a 2-entry valid/ready buffer.
// A redirect flushes the buffer and restarts fetch at the new target. Fetch
// halts once the PC reaches MEM_LIMIT.
//
// Parameters:
//   RESET_PC   PC loaded on reset (word aligned)
//   PC_STEP    byte increment between sequential fetches
//   MEM_LIMIT  first byte address outside instruction memory
//
// Ports:
//   clk              clock, all state updates on posedge
//   reset            asynchronous active-high reset
//   imem_addr        read address to instruction memory (registered pc)
//   imem_rdata       instruction word for imem_addr, same cycle
//   redirect_valid   taken branch/jump: flush and restart fetch
//   redirect_target  new fetch byte address, bits [1:0] ignored
//   out_valid        buffer head holds a valid instruction
//   out_ready        decode accepts the head this cycle
//   out_instr        instruction at buffer head
//   out_pc           byte address of out_instr
//   fetch_oob        pc at/after MEM_LIMIT, fetching halted
//
// Optional build macro FETCH_PERF_CNT_EN adds saturating counters:
//   perf_fetched     number of fetches pushed into the buffer
//   perf_flushed     number of buffered entries discarded by redirects
//
// FSM states:
//   state | meaning
//   BOOT  | first cycle after reset; memory loads, no fetch
//   RUN   | normal fetching, permanent until reset
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] PC_STEP   = 32'd4,
  parameter logic [31:0] MEM_LIMIT = 32'd64
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fetch_oob
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;

  // Buffer kept as head/tail registers: head always feeds the outputs, so
  // out_pc/out_instr naturally hold their last value when the buffer empties.
  logic [31:0] head_pc_q, head_pc_d;
  logic [31:0] head_instr_q, head_instr_d;
  logic [31:0] tail_pc_q, tail_pc_d;
  logic [31:0] tail_instr_q, tail_instr_d;

  logic pop;
  logic fire;

  // The target's byte offset is dropped; fetch is always word aligned.
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^redirect_target[1:0];

  assign imem_addr = pc_q;
  assign out_valid = (count_q != 2'd0);
  assign out_pc    = head_pc_q;
  assign out_instr = head_instr_q;
  assign fetch_oob = (state_q == RUN) && (pc_q >= MEM_LIMIT);

  assign pop  = out_valid && out_ready;
  assign fire = (state_q == RUN) && !redirect_valid && !fetch_oob &&
                ((count_q < 2'd2) || pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      count_q      <= 2'd0;
      head_pc_q    <= 32'd0;
      head_instr_q <= 32'd0;
      tail_pc_q    <= 32'd0;
      tail_instr_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      count_q      <= count_d;
      head_pc_q    <= head_pc_d;
      head_instr_q <= head_instr_d;
      tail_pc_q    <= tail_pc_d;
      tail_instr_q <= tail_instr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    count_d      = count_q;
    head_pc_d    = head_pc_q;
    head_instr_d = head_instr_q;
    tail_pc_d    = tail_pc_q;
    tail_instr_d = tail_instr_q;

    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase

    if (redirect_valid) begin
      // Flush wins over everything, including a concurrent pop.
      count_d = 2'd0;
      pc_d    = {redirect_target[31:2], 2'b00};
    end else begin
      if (fire) begin
        pc_d = pc_q + PC_STEP;
      end
      case ({fire, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_pc_d    = pc_q;
            head_instr_d = imem_rdata;
          end else begin
            tail_pc_d    = pc_q;
            tail_instr_d = imem_rdata;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd2) begin
            head_pc_d    = tail_pc_q;
            head_instr_d = tail_instr_q;
          end
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Count unchanged; the new word goes behind whatever remains.
          if (count_q == 2'd1) begin
            head_pc_d    = pc_q;
            head_instr_d = imem_rdata;
          end else begin
            head_pc_d    = tail_pc_q;
            head_instr_d = tail_instr_q;
            tail_pc_d    = pc_q;
            tail_instr_d = imem_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [32:0] flushed_sum;
  assign flushed_sum = {1'b0, perf_flushed} + {31'd0, count_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= 32'd0;
      perf_flushed <= 32'd0;
    end else begin
      if (fire && (perf_fetched != 32'hFFFF_FFFF)) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (redirect_valid) begin
        perf_flushed <= flushed_sum[32] ? 32'hFFFF_FFFF : flushed_sum[31:0];
      end
    end
  end
`endif

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Initiator side of the instruction memory interface. Holds the PC and drives the byte read address. Captures the combinational instruction word returned in the same cycle and hands {pc, instruction} pairs to decode through a 2-entry valid/ready buffer. Supports branch/jump redirect with flush and stops cleanly at the end of the memory window.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; low 2 bits must be zero
PC_STEP, 4, byte increment between sequential fetches
MEM_LIMIT, 64, first byte address outside instruction memory; fetch is blocked at pc >= MEM_LIMIT

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  asynchronous, active-high reset
imem_addr  output  32  read address to instruction memory, always equal to pc register
imem_rdata  input  32  instruction word for imem_addr, valid in the same cycle (combinational read)
redirect_valid  input  1  taken branch/jump: flush and restart fetch
redirect_target  input  32  new fetch byte address; bits [1:0] ignored
out_valid  output  1  buffer head holds a valid instruction
out_ready  input  1  decode accepts head this cycle
out_instr  output  32  instruction at buffer head
out_pc  output  32  byte address of out_instr
fetch_oob  output  1  pc has reached/passed MEM_LIMIT; fetching halted

Behaviour:
- Reset (async, any time, including mid-stream):
  - pc=RESET_PC, buffer count=0, out_valid=0, out_instr=0, out_pc=0, fetch_oob=0, state=BOOT.
  - Buffered entries are discarded.
- States: BOOT -> RUN.
  - BOOT lasts exactly one cycle after reset deasserts; no fetch, imem_addr=RESET_PC. This lets instruction memory load its contents on that edge.
  - RUN is permanent until reset.
- fetch_oob = (state==RUN) && (pc >= MEM_LIMIT), compared unsigned. Combinational from registered pc.
- pop = out_valid && out_ready.
- fire = (state==RUN) && !redirect_valid && !fetch_oob && (count<2 || pop).
- On fire:
  - push {pc, imem_rdata} at buffer tail.
  - pc <= pc + PC_STEP, 32-bit wrap.
- Pop removes the head; out_instr/out_pc present the next entry in the following cycle.
- Push and pop in the same cycle: count is unchanged and ordering is preserved (FIFO). Full plus pop still allows a push.
- Buffer is 2 entries, count 0..2.
  - out_valid = (count != 0).
  - out_instr/out_pc hold their last values when count==0.
- Redirect has highest priority in RUN and in BOOT:
  - count <= 0; pc <= {redirect_target[31:2], 2'b00}.
  - No push that cycle; a concurrent pop is discarded with the flush.
  - fetch_oob re-evaluates from the new pc, so a redirect to an in-range target clears it.
- Latency:
  - A fetch in cycle N produces out_valid=1 in cycle N+1.
  - A redirect in cycle N causes fetch at the target in N+1 and out_valid at N+2.
  - Sustained throughput is 1 instruction/cycle with out_ready held high.
- Backpressure: with out_ready=0, at most 2 entries are taken, then pc freezes. No instruction is dropped or duplicated.
- imem_addr changes only at clock edges (registered pc).

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs perf_fetched[31:0] (increments on each fire) and perf_flushed[31:0] (increments by count-before-flush on each redirect).
  - Both counters are 0 on reset and saturate at 32'hFFFF_FFFF.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Stream: reset 3 cycles, out_ready=1, memory loaded with the standard program -> out_pc 0,4,8,12 on consecutive cycles; at out_pc=4 out_instr=32'h019806B3; no gaps after the first valid.
- Backpressure: out_ready=0 for 6 cycles after first valid -> count stays 2, imem_addr frozen at 8, out_pc holds 0. Release out_ready -> out_pc 0,4,8 in order with no duplicates.
- Redirect: buffer full, redirect_valid=1 with target 44 and out_ready=1 in the same cycle -> out_valid=0 next cycle; two cycles later out_pc=44, out_instr=32'h00948663.
- Misaligned target: redirect_target=32'h2E -> imem_addr=32'h2C next cycle.
- Boundary: run from 0 with out_ready=1 -> last out_pc=60; fetch_oob=1 once pc=64; out_valid falls after 60 is consumed. Redirect to 0 -> fetch_oob=0 and fetch restarts.
- Reset mid-stream: assert reset asynchronously with 2 entries buffered -> out_valid=0 and imem_addr=0 immediately. After deassert: one BOOT cycle, then out_pc=0 again.
